argmax_digit: RTL and testbench

- Sits directly upstream of the seven-segment display driver.
- Consumes the output layer's per-class scores as a serial valid/ready stream, one frame of NUM_CLASSES beats per image.
- Selects the class with the largest signed score and presents it as a 4-bit digit, with its winning score and a frame-error flag, on a valid/ready result port.
- The display stage latches the digit on result acceptance.

---
 rtl/argmax_digit_pkg.sv | 15 +
 rtl/argmax_cmp.sv | 21 ++
 rtl/argmax_digit.sv | 96 +++++++++
 tb/tb_argmax_digit.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/argmax_digit_pkg.sv
// rtl/argmax_digit_pkg.sv - shared classifier constants and argmax state encoding
package argmax_digit_pkg;

    localparam int NUM_CLASSES = 10;
    localparam int SCORE_W     = 16;
    localparam int IDX_W       = 4;
    // Beat counter must be able to sit at NUM_CLASSES once a frame overruns.
    localparam int CNT_W       = $clog2(NUM_CLASSES + 1);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

endpackage

// File: rtl/argmax_cmp.sv
// rtl/argmax_cmp.sv - one argmax step: strict-greater update, lower index wins ties
module argmax_cmp
    import argmax_digit_pkg::*;
(
    input  logic signed [SCORE_W-1:0] cur_score,
    input  logic        [IDX_W-1:0]   cur_idx,
    input  logic signed [SCORE_W-1:0] best_score,
    input  logic        [IDX_W-1:0]   best_idx,
    input  logic                      first,
    output logic signed [SCORE_W-1:0] new_score,
    output logic        [IDX_W-1:0]   new_idx
);

    logic take;

    // Equal scores never replace, so the earlier (lower) index is kept.
    assign take      = first || (cur_score > best_score);
    assign new_score = take ? cur_score : best_score;
    assign new_idx   = take ? cur_idx   : best_idx;

endmodule

// File: rtl/argmax_digit.sv
// rtl/argmax_digit.sv - frame-serial argmax over class scores feeding the digit display
module argmax_digit
    import argmax_digit_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      score_valid,
    output logic                      score_ready,
    input  logic signed [SCORE_W-1:0] score_data,
    input  logic                      score_last,
    output logic                      result_valid,
    input  logic                      result_ready,
    output logic        [IDX_W-1:0]   result_digit,
    output logic signed [SCORE_W-1:0] result_score,
    output logic                      result_err
);

    state_t                    state;
    logic        [CNT_W-1:0]   beat_idx;
    logic signed [SCORE_W-1:0] best_score;
    logic        [IDX_W-1:0]   best_idx;
    logic                      len_err;

    logic                      beat_xfer;
    logic                      result_xfer;
    logic                      in_range;
    logic signed [SCORE_W-1:0] cmp_score;
    logic        [IDX_W-1:0]   cmp_idx;
    logic signed [SCORE_W-1:0] upd_score;
    logic        [IDX_W-1:0]   upd_idx;

    assign score_ready  = (state == ACCUM);
    assign result_valid = (state == HOLD);
    assign beat_xfer    = score_valid && score_ready;
    assign result_xfer  = result_valid && result_ready;
    assign in_range     = (beat_idx < CNT_W'(NUM_CLASSES));

    argmax_cmp u_cmp (
        .cur_score  (score_data),
        .cur_idx    (IDX_W'(beat_idx)),
        .best_score (best_score),
        .best_idx   (best_idx),
        .first      (beat_idx == '0),
        .new_score  (cmp_score),
        .new_idx    (cmp_idx)
    );

    // Overrun beats leave the running best untouched.
    assign upd_score = in_range ? cmp_score : best_score;
    assign upd_idx   = in_range ? cmp_idx   : best_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ACCUM;
            beat_idx     <= '0;
            best_score   <= '0;
            best_idx     <= '0;
            len_err      <= 1'b0;
            result_digit <= '0;
            result_score <= '0;
            result_err   <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (beat_xfer) begin
                        if (score_last) begin
                            result_digit <= upd_idx;
                            result_score <= upd_score;
                            result_err   <= len_err || (beat_idx != CNT_W'(NUM_CLASSES - 1));
                            state        <= HOLD;
                            beat_idx     <= '0;
                            best_score   <= '0;
                            best_idx     <= '0;
                            len_err      <= 1'b0;
                        end else begin
                            best_score <= upd_score;
                            best_idx   <= upd_idx;
                            if (in_range) begin
                                beat_idx <= beat_idx + 1'b1;
                            end else begin
                                len_err <= 1'b1;
                            end
                        end
                    end
                end
                HOLD: begin
                    if (result_xfer) begin
                        state <= ACCUM;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_argmax_digit.sv
// tb/tb_argmax_digit.sv - self-checking bench for argmax_digit
module tb_argmax_digit;
    import argmax_digit_pkg::*;

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic                      score_valid;
    logic                      score_ready;
    logic signed [SCORE_W-1:0] score_data;
    logic                      score_last;
    logic                      result_valid;
    logic                      result_ready;
    logic        [IDX_W-1:0]   result_digit;
    logic signed [SCORE_W-1:0] result_score;
    logic                      result_err;

    always #5 clk = ~clk;

    argmax_digit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .score_valid  (score_valid),
        .score_ready  (score_ready),
        .score_data   (score_data),
        .score_last   (score_last),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .result_digit (result_digit),
        .result_score (result_score),
        .result_err   (result_err)
    );

    typedef struct {
        int               len;
        logic [15:0][15:0] s;
        int               digit;
        int               score;
        int               err;
    } vec_t;

    vec_t vecs[5];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input int len, input int vals[16], input int d, input int sc, input int e);
        vec_t v;
        v.len = len;
        for (int i = 0; i < 16; i++) v.s[i] = 16'(vals[i]);
        v.digit = d;
        v.score = sc;
        v.err   = e;
        return v;
    endfunction

    // Reference: best over the first NUM_CLASSES beats, first occurrence of the maximum.
    function automatic void model(input int len, input logic [15:0][15:0] s,
                                  output int d, output int sc, output int e);
        int v;
        d  = 0;
        sc = $signed(s[0]);
        for (int i = 1; i < len && i < NUM_CLASSES; i++) begin
            v = $signed(s[i]);
            if (v > sc) begin
                sc = v;
                d  = i;
            end
        end
        e = (len != NUM_CLASSES) ? 1 : 0;
    endfunction

    task automatic send_beat(input logic [15:0] d, input logic last, input bit gaps);
        int n;
        if (gaps) begin
            n = $urandom_range(0, 2);
            repeat (n) begin
                score_valid = 1'b0;
                tick();
            end
        end
        score_valid = 1'b1;
        score_data  = d;
        score_last  = last;
        n = 0;
        while (!score_ready && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) check("beat_timeout", 1, 0);
        tick();
        score_valid = 1'b0;
        score_last  = 1'b0;
    endtask

    task automatic get_result(input string name, input int d, input int sc, input int e,
                              input int hold, input bit present);
        int stable;
        check({name, "_valid"}, int'(result_valid), 1);
        check({name, "_digit"}, int'(result_digit), d);
        check({name, "_score"}, int'(result_score), sc);
        check({name, "_err"}, int'(result_err), e);
        if (present) begin
            score_valid = 1'b1;
            score_data  = 16'sh7FFF;
            score_last  = 1'b1;
        end
        stable = 1;
        for (int i = 0; i < hold; i++) begin
            tick();
            if (score_ready !== 1'b0 || result_valid !== 1'b1 || int'(result_digit) != d
                || int'(result_score) != sc || int'(result_err) != e) stable = 0;
        end
        if (hold > 0) check({name, "_hold_stable"}, stable, 1);
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        score_valid  = 1'b0;
        score_last   = 1'b0;
        check({name, "_valid_drop"}, int'(result_valid), 0);
        check({name, "_ready_back"}, int'(score_ready), 1);
    endtask

    task automatic run_frame(input string name, input vec_t v, input bit gaps,
                             input int hold, input bit present);
        for (int i = 0; i < v.len; i++) send_beat(v.s[i], (i == v.len - 1), gaps);
        get_result(name, v.digit, v.score, v.err, hold, present);
    endtask

    initial begin
        vec_t r;
        int   d, sc, e, len;
        vecs[0] = mk(10, '{5, -3, 12, 7, 12, 0, -100, 11, 2, 1, 0, 0, 0, 0, 0, 0}, 2, 12, 0);
        vecs[1] = mk(10, '{-32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768,
                           -32768, -1, 0, 0, 0, 0, 0, 0}, 9, -1, 0);
        vecs[2] = mk(7, '{1, 2, 3, 9, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0}, 3, 9, 1);
        vecs[3] = mk(12, '{1, 2, 3, 4, 5, 6, 20, 7, 8, 9, 30, 50, 0, 0, 0, 0}, 6, 20, 1);
        vecs[4] = mk(1, '{-5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0}, 0, -5, 1);

        rst_n        = 1'b0;
        score_valid  = 1'b0;
        score_data   = '0;
        score_last   = 1'b0;
        result_ready = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
        check("rst_ready", int'(score_ready), 1);
        check("rst_valid", int'(result_valid), 0);
        check("rst_digit", int'(result_digit), 0);
        check("rst_score", int'(result_score), 0);
        check("rst_err", int'(result_err), 0);

        for (int i = 0; i < 5; i++) run_frame($sformatf("vec%0d", i), vecs[i], 1'b0, 0, 1'b0);

        run_frame("backpressure", vecs[0], 1'b0, 20, 1'b1);
        run_frame("after_bp", vecs[1], 1'b0, 0, 1'b0);
        run_frame("gaps", vecs[0], 1'b1, 0, 1'b0);

        for (int i = 0; i < 5; i++) send_beat(16'sh7FFF, 1'b0, 1'b0);
        rst_n = 1'b0;
        #2;
        check("rstmid_valid", int'(result_valid), 0);
        check("rstmid_digit", int'(result_digit), 0);
        check("rstmid_score", int'(result_score), 0);
        check("rstmid_ready", int'(score_ready), 1);
        #3 rst_n = 1'b1;
        tick();
        run_frame("post_rstmid", vecs[1], 1'b0, 0, 1'b0);

        for (int i = 0; i < vecs[0].len; i++) send_beat(vecs[0].s[i], (i == vecs[0].len - 1), 1'b0);
        check("prehold_valid", int'(result_valid), 1);
        rst_n = 1'b0;
        #2;
        check("rsthold_valid", int'(result_valid), 0);
        check("rsthold_digit", int'(result_digit), 0);
        check("rsthold_score", int'(result_score), 0);
        check("rsthold_err", int'(result_err), 0);
        #3 rst_n = 1'b1;
        tick();
        run_frame("post_rsthold", vecs[1], 1'b0, 0, 1'b0);

        for (int f = 0; f < 40; f++) begin
            len = ($urandom_range(0, 1) == 1) ? NUM_CLASSES : int'($urandom_range(1, 14));
            r.len = len;
            for (int i = 0; i < 16; i++) begin
                if ($urandom_range(0, 3) == 0) r.s[i] = 16'($urandom);
                else r.s[i] = 16'(int'($urandom_range(0, 20)) - 10);
            end
            model(len, r.s, d, sc, e);
            r.digit = d;
            r.score = sc;
            r.err   = e;
            run_frame($sformatf("rand%0d", f), r, 1'($urandom_range(0, 1)),
                      int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
